// File: rtl/cp0_ctrl_if.sv
// Core <-> coprocessor-0 bus: mfc0/mtc0/eret requests, exception entry and PC redirect.
// The master modport is the pipeline side; the slave modport is cp0_ctrl.
interface cp0_ctrl_if #(
    parameter int unsigned NUM_IRQ = 6
);
    logic                 mfc0;
    logic                 mtc0;
    logic                 eret;
    logic                 exc_valid;
    logic [4:0]           exc_code;
    logic                 exc_bd;
    logic [31:0]          exc_badvaddr;
    logic [4:0]           addr;
    logic [31:0]          wdata;
    logic [31:0]          pc;
    logic [NUM_IRQ-1:0]   irq;
    logic [31:0]          rdata;
    logic [31:0]          status_out;
    logic [31:0]          epc_out;
    logic                 int_req;
    logic                 exc_taken;
    logic                 eret_taken;
    logic [31:0]          target_pc;

    modport master (
        output mfc0, mtc0, eret, exc_valid, exc_code, exc_bd, exc_badvaddr,
        output addr, wdata, pc, irq,
        input  rdata, status_out, epc_out, int_req, exc_taken, eret_taken, target_pc
    );

    modport slave (
        input  mfc0, mtc0, eret, exc_valid, exc_code, exc_bd, exc_badvaddr,
        input  addr, wdata, pc, irq,
        output rdata, status_out, epc_out, int_req, exc_taken, eret_taken, target_pc
    );
endinterface

// File: rtl/cp0_ctrl.sv
// MIPS coprocessor 0: Status/Cause/EPC/BadVAddr/Count/Compare, exception entry, eret and
// the Count/Compare timer interrupt. Priority per cycle is exception > eret > mtc0.
module cp0_ctrl #(
    parameter int unsigned NUM_IRQ    = 6,
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
    parameter logic [31:0] STATUS_RST = 32'h0000_0000,
    parameter int unsigned COUNT_DIV  = 1
) (
    input  logic     clk,
    input  logic     rst,
    cp0_ctrl_if.slave cp0
);
    localparam logic [4:0] AddrBadVAddr = 5'd8;
    localparam logic [4:0] AddrCount    = 5'd9;
    localparam logic [4:0] AddrCompare  = 5'd11;
    localparam logic [4:0] AddrStatus   = 5'd12;
    localparam logic [4:0] AddrCause    = 5'd13;
    localparam logic [4:0] AddrEpc      = 5'd14;
    localparam logic [3:0] DivMax       = 4'(COUNT_DIV - 1);

    logic [31:0]        status_q, status_d;
    logic [31:0]        epc_q, epc_d;
    logic [31:0]        badvaddr_q, badvaddr_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        compare_q, compare_d;
    logic [3:0]         div_q, div_d;
    logic               timer_q, timer_d;
    logic               bd_q, bd_d;
    logic [4:0]         exccode_q, exccode_d;
    logic [1:0]         ip_sw_q, ip_sw_d;
    logic [NUM_IRQ-1:0] irq_q, irq_d;

    logic [7:0]  ip;
    logic [31:0] cause;
    logic        exc_en;
    logic        eret_en;
    logic        wr_en;

    assign exc_en  = cp0.exc_valid;
    assign eret_en = cp0.eret & ~cp0.exc_valid;
    assign wr_en   = cp0.mtc0 & ~cp0.exc_valid & ~cp0.eret;

    // Lines beyond IP6 have no slot of their own and share IP7 with the timer.
    always_comb begin
        ip      = '0;
        ip[1:0] = ip_sw_q;
        ip[7]   = timer_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (i < 5) begin
                ip[2 + i] = irq_q[i];
            end else begin
                ip[7] = ip[7] | irq_q[i];
            end
        end
    end

    assign cause = {bd_q, 15'b0, ip, 1'b0, exccode_q, 2'b00};

    always_comb begin
        status_d   = status_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        compare_d  = compare_q;
        div_d      = div_q + 4'd1;
        timer_d    = timer_q | (count_q == compare_q);
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        ip_sw_d    = ip_sw_q;
        irq_d      = cp0.irq;

        if (div_q == DivMax) begin
            div_d   = '0;
            count_d = count_q + 32'd1;
        end

        if (exc_en) begin
            exccode_d   = cp0.exc_code;
            status_d[1] = 1'b1;
            if (!status_q[1]) begin
                epc_d = cp0.exc_bd ? (cp0.pc - 32'd4) : cp0.pc;
                bd_d  = cp0.exc_bd;
            end
            if (cp0.exc_code == 5'd4 || cp0.exc_code == 5'd5) begin
                badvaddr_d = cp0.exc_badvaddr;
            end
        end else if (eret_en) begin
            status_d[1] = 1'b0;
        end else if (wr_en) begin
            // BadVAddr is hardware-owned; writes to it fall through to the default.
            case (cp0.addr)
                AddrCount: begin
                    count_d = cp0.wdata;
                    div_d   = '0;
                end
                AddrCompare: begin
                    compare_d = cp0.wdata;
                    timer_d   = 1'b0;
                end
                AddrStatus: status_d = cp0.wdata;
                AddrCause:  ip_sw_d  = cp0.wdata[9:8];
                AddrEpc:    epc_d    = cp0.wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q   <= STATUS_RST;
            epc_q      <= '0;
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            div_q      <= '0;
            timer_q    <= 1'b0;
            bd_q       <= 1'b0;
            exccode_q  <= '0;
            ip_sw_q    <= '0;
            irq_q      <= '0;
        end else begin
            status_q   <= status_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            div_q      <= div_d;
            timer_q    <= timer_d;
            bd_q       <= bd_d;
            exccode_q  <= exccode_d;
            ip_sw_q    <= ip_sw_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        cp0.rdata = '0;
        if (cp0.mfc0) begin
            case (cp0.addr)
                AddrBadVAddr: cp0.rdata = badvaddr_q;
                AddrCount:    cp0.rdata = count_q;
                AddrCompare:  cp0.rdata = compare_q;
                AddrStatus:   cp0.rdata = status_q;
                AddrCause:    cp0.rdata = cause;
                AddrEpc:      cp0.rdata = epc_q;
                default:      cp0.rdata = '0;
            endcase
        end
    end

    always_comb begin
        cp0.target_pc = '0;
        if (exc_en) begin
            cp0.target_pc = EXC_VECTOR;
        end else if (eret_en) begin
            cp0.target_pc = epc_q;
        end
    end

    assign cp0.exc_taken  = exc_en;
    assign cp0.eret_taken = eret_en;
    assign cp0.status_out = status_q;
    assign cp0.epc_out    = epc_q;
    assign cp0.int_req    = status_q[0] & ~status_q[1] & |(ip & status_q[15:8]);
endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl: register access, interrupts, exceptions, timer,
// request priority and asynchronous reset, against hand-computed values.
module tb_cp0_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errs;
    logic [31:0] rd;

    cp0_ctrl_if #(.NUM_IRQ(6)) bus ();

    cp0_ctrl #(
        .NUM_IRQ    (6),
        .EXC_VECTOR (32'h0040_0004),
        .STATUS_RST (32'h0000_0000),
        .COUNT_DIV  (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .cp0 (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge after the write edge.
    task automatic mtc(input logic [4:0] a, input logic [31:0] d);
        bus.mtc0  = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        @(negedge clk);
        bus.mtc0  = 1'b0;
    endtask

    task automatic mfc(input logic [4:0] a, output logic [31:0] v);
        bus.mfc0 = 1'b1;
        bus.addr = a;
        #1;
        v = bus.rdata;
        bus.mfc0 = 1'b0;
    endtask

    initial begin
        n_checks          = 0;
        n_errs            = 0;
        rst               = 1'b1;
        bus.mfc0          = 1'b0;
        bus.mtc0          = 1'b0;
        bus.eret          = 1'b0;
        bus.exc_valid     = 1'b0;
        bus.exc_code      = '0;
        bus.exc_bd        = 1'b0;
        bus.exc_badvaddr  = '0;
        bus.addr          = '0;
        bus.wdata         = '0;
        bus.pc            = '0;
        bus.irq           = '0;
        repeat (2) @(negedge clk);

        check("rst_status", bus.status_out, 32'h0);
        check("rst_epc", bus.epc_out, 32'h0);
        check("rst_int_req", 32'(bus.int_req), 32'h0);
        check("rst_exc_taken", 32'(bus.exc_taken), 32'h0);
        check("rst_eret_taken", 32'(bus.eret_taken), 32'h0);
        check("rst_target_pc", bus.target_pc, 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Register access
        mtc(5'd12, 32'h0000_FF01);
        mfc(5'd12, rd); check("rd_status", rd, 32'h0000_FF01);
        mfc(5'd3, rd);  check("rd_unmapped", rd, 32'h0);
        #1 check("rdata_idle", bus.rdata, 32'h0);

        // External interrupt and interrupt entry
        mtc(5'd11, 32'hFFFF_0000);
        mtc(5'd12, 32'h0000_0401);
        bus.irq = 6'b000001;
        #1 check("irq_latency", 32'(bus.int_req), 32'h0);
        @(negedge clk);
        check("int_req_irq0", 32'(bus.int_req), 32'h1);
        mfc(5'd13, rd); check("cause_ip2", rd, 32'h0000_0400);
        bus.exc_valid = 1'b1;
        bus.exc_code  = 5'd0;
        bus.pc        = 32'h0040_0100;
        #1;
        check("int_exc_taken", 32'(bus.exc_taken), 32'h1);
        check("int_target", bus.target_pc, 32'h0040_0004);
        check("int_no_eret", 32'(bus.eret_taken), 32'h0);
        @(negedge clk);
        bus.exc_valid = 1'b0;
        bus.irq       = '0;
        check("int_epc", bus.epc_out, 32'h0040_0100);
        check("int_status_exl", bus.status_out, 32'h0000_0403);
        check("int_req_masked", 32'(bus.int_req), 32'h0);

        bus.eret = 1'b1;
        #1;
        check("eret1_taken", 32'(bus.eret_taken), 32'h1);
        check("eret1_target", bus.target_pc, 32'h0040_0100);
        @(negedge clk);
        bus.eret = 1'b0;
        check("eret1_status", bus.status_out, 32'h0000_0401);

        // Address error in a delay slot, then a nested exception
        bus.exc_valid    = 1'b1;
        bus.exc_code     = 5'd4;
        bus.exc_bd       = 1'b1;
        bus.pc           = 32'h0040_0208;
        bus.exc_badvaddr = 32'h1000_0003;
        @(negedge clk);
        bus.exc_valid = 1'b0;
        bus.exc_bd    = 1'b0;
        check("bd_epc", bus.epc_out, 32'h0040_0204);
        mfc(5'd13, rd); check("bd_cause", rd, 32'h8000_0010);
        mfc(5'd8, rd);  check("bd_badvaddr", rd, 32'h1000_0003);
        bus.exc_valid    = 1'b1;
        bus.exc_code     = 5'd6;
        bus.pc           = 32'h0040_0300;
        bus.exc_badvaddr = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.exc_valid = 1'b0;
        check("nest_epc", bus.epc_out, 32'h0040_0204);
        mfc(5'd13, rd); check("nest_cause", rd, 32'h8000_0018);
        mfc(5'd8, rd);  check("nest_badvaddr", rd, 32'h1000_0003);

        // Exception, eret and mtc0 together: only the exception happens
        bus.exc_valid = 1'b1;
        bus.exc_code  = 5'd0;
        bus.pc        = 32'h0040_0500;
        bus.eret      = 1'b1;
        bus.mtc0      = 1'b1;
        bus.addr      = 5'd12;
        bus.wdata     = 32'h0;
        #1;
        check("prio_exc_taken", 32'(bus.exc_taken), 32'h1);
        check("prio_eret_taken", 32'(bus.eret_taken), 32'h0);
        check("prio_target", bus.target_pc, 32'h0040_0004);
        @(negedge clk);
        bus.exc_valid = 1'b0;
        bus.eret      = 1'b0;
        bus.mtc0      = 1'b0;
        check("prio_status", bus.status_out, 32'h0000_0403);
        check("prio_epc", bus.epc_out, 32'h0040_0204);
        bus.eret = 1'b1;
        #1;
        check("eret2_taken", 32'(bus.eret_taken), 32'h1);
        check("eret2_target", bus.target_pc, 32'h0040_0204);
        @(negedge clk);
        bus.eret = 1'b0;
        check("eret2_status", bus.status_out, 32'h0000_0401);

        // Count/Compare timer
        mtc(5'd12, 32'h0000_8001);
        mtc(5'd11, 32'd5);
        mtc(5'd9, 32'd0);
        mfc(5'd9, rd); check("count_loaded", rd, 32'd0);
        repeat (5) @(negedge clk);
        mfc(5'd9, rd); check("count_at_5", rd, 32'd5);
        check("timer_not_yet", 32'(bus.int_req), 32'h0);
        @(negedge clk);
        check("timer_int_req", 32'(bus.int_req), 32'h1);
        mfc(5'd13, rd); check("timer_cause_ip7", rd, 32'h8000_8000);
        @(negedge clk);
        check("timer_holds", 32'(bus.int_req), 32'h1);
        mtc(5'd11, 32'd1000);
        check("timer_cleared", 32'(bus.int_req), 32'h0);
        mtc(5'd9, 32'hFFFF_FFFF);
        mfc(5'd9, rd); check("count_max", rd, 32'hFFFF_FFFF);
        @(negedge clk);
        mfc(5'd9, rd); check("count_wrap", rd, 32'h0);

        // Asynchronous reset in the middle of counting
        mtc(5'd9, 32'd37);
        mfc(5'd9, rd); check("count_37", rd, 32'd37);
        rst = 1'b1;
        mfc(5'd9, rd);  check("arst_count", rd, 32'h0);
        mfc(5'd13, rd); check("arst_cause", rd, 32'h0);
        mfc(5'd14, rd); check("arst_epc", rd, 32'h0);
        mfc(5'd12, rd); check("arst_status", rd, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
